// File: rtl/ev20_pkg.sv
// ----------------------------------------------------------------------------
// ev20_pkg
// Shared definitions for the EV20 fetch front end.
//   ADDR_W          : default program-counter width
//   STACK_DEPTH     : default return-stack depth of the branch/return stage
//   ST_*            : pc_sequencer FSM state encoding
//   FAULT_*         : fault_code values reported by pc_sequencer
// ----------------------------------------------------------------------------
package ev20_pkg;

   localparam int ADDR_W      = 11;
   localparam int STACK_DEPTH = 4;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_RUN      = 2'd1;
   localparam logic [1:0] ST_WAIT_TGT = 2'd2;
   localparam logic [1:0] ST_FAULT    = 2'd3;

   localparam logic [1:0] FAULT_NONE      = 2'b00;
   localparam logic [1:0] FAULT_OVERFLOW  = 2'b01;
   localparam logic [1:0] FAULT_UNDERFLOW = 2'b10;

endpackage

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
// Program-counter sequencer: generates the fetch address, handles absolute
// jumps locally and hands subroutine call/return to the downstream
// branch/return stage, waiting one cycle for its target.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   hold       in   run-enable (1 = advance, 0 = freeze)
//   branch     in   subroutine-call request
//   ret        in   subroutine-return request
//   jump       in   absolute-jump request
//   jump_addr  in   absolute-jump target
//   target_pc  in   call/return target, valid the cycle after acceptance
//   level      in   current call depth from the branch/return stage
//   pc         out  current fetch address
//   fetch_en   out  pc is a valid fetch this cycle
//   flush      out  discard the instruction fetched the previous cycle
//   fault      out  sticky stack fault
//   fault_code out  00 none, 01 overflow, 10 underflow
// ----------------------------------------------------------------------------
module pc_sequencer #(
   parameter int                ADDR_W       = ev20_pkg::ADDR_W,
   parameter int                STACK_DEPTH  = ev20_pkg::STACK_DEPTH,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hold,
   input  logic              branch,
   input  logic              ret,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_addr,
   input  logic [ADDR_W-1:0] target_pc,
   input  logic [2:0]        level,
   output logic [ADDR_W-1:0] pc,
   output logic              fetch_en,
   output logic              flush,
   output logic              fault,
   output logic [1:0]        fault_code
);

   import ev20_pkg::*;

   logic [1:0]        state;
   logic [1:0]        state_nx;
   logic [ADDR_W-1:0] pc_nx;
   logic              fetch_nx;
   logic              flush_nx;
   logic              fault_nx;
   logic [1:0]        code_nx;

   // Next-state and next-output logic. fetch_en and flush default low so
   // they are single-cycle unless a request re-asserts them; hold=0 leaves
   // everything else at its current value.
   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      fetch_nx = 1'b0;
      flush_nx = 1'b0;
      fault_nx = fault;
      code_nx  = fault_code;
      if (hold) begin
         case (state)
            ST_IDLE: begin
               // First enabled edge starts fetching at the current pc.
               state_nx = ST_RUN;
               fetch_nx = 1'b1;
            end
            ST_RUN: begin
               // Branch wins over ret when both are raised together.
               if (branch) begin
                  if (int'(level) < STACK_DEPTH) begin
                     state_nx = ST_WAIT_TGT;
                     flush_nx = 1'b1;
                  end else begin
                     state_nx = ST_FAULT;
                     fault_nx = 1'b1;
                     code_nx  = FAULT_OVERFLOW;
                  end
               end else if (ret) begin
                  if (level != 3'd0) begin
                     state_nx = ST_WAIT_TGT;
                     flush_nx = 1'b1;
                  end else begin
                     state_nx = ST_FAULT;
                     fault_nx = 1'b1;
                     code_nx  = FAULT_UNDERFLOW;
                  end
               end else if (jump) begin
                  pc_nx    = jump_addr;
                  fetch_nx = 1'b1;
                  flush_nx = 1'b1;
               end else begin
                  pc_nx    = pc + ADDR_W'(1);
                  fetch_nx = 1'b1;
               end
            end
            ST_WAIT_TGT: begin
               // The branch/return stage presents its target now; any new
               // request in this cycle is dropped.
               state_nx = ST_RUN;
               pc_nx    = target_pc;
               fetch_nx = 1'b1;
            end
            default: begin
               // Fault is absorbing until reset.
               state_nx = ST_FAULT;
            end
         endcase
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         pc         <= RESET_VECTOR;
         fetch_en   <= 1'b0;
         flush      <= 1'b0;
         fault      <= 1'b0;
         fault_code <= FAULT_NONE;
      end else begin
         state      <= state_nx;
         pc         <= pc_nx;
         fetch_en   <= fetch_nx;
         flush      <= flush_nx;
         fault      <= fault_nx;
         fault_code <= code_nx;
      end
   end

endmodule
